nasti_dma_mover: RTL and testbench

- Data-mover engine at the far end of the DMA controller's enable/done handshake.
- On an enable it latches a source address, destination address and byte length, then copies the data over a NASTI (AXI4) master port as bursts: read a burst into an internal buffer, write it back out, repeat until done.
- One instance serves one direction. The controller's a->b and b->a enables each drive a separate instance.

---
 rtl/nasti_dma_mover.sv | 249 ++++++++++++++++++++++++
 tb/tb_nasti_dma_mover.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_dma_mover.sv
// NASTI (AXI4) burst data mover: copies `length` bytes from src_addr to dest_addr
// by reading a burst into a local buffer and writing it back out, chunk by chunk.
module nasti_dma_mover #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      en,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [ADDR_WIDTH-1:0]     dest_addr,
    input  logic [ADDR_WIDTH-1:0]     length,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_WIDTH-1:0]     ar_addr,
    output logic [7:0]                ar_len,
    output logic [2:0]                ar_size,
    output logic [1:0]                ar_burst,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_last,
    input  logic                      r_valid,
    output logic                      r_ready,
    output logic [ADDR_WIDTH-1:0]     aw_addr,
    output logic [7:0]                aw_len,
    output logic [2:0]                aw_size,
    output logic [1:0]                aw_burst,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic                      w_last,
    output logic                      w_valid,
    input  logic                      w_ready,
    input  logic [1:0]                b_resp,
    input  logic                      b_valid,
    output logic                      b_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int NW    = $clog2(MAX_BURST) + 1;
    localparam int IW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [NW-1:0] N_ONE = NW'(1'b1);
    localparam logic [NW-1:0] N_TWO = NW'(2'd2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   src_r;
    logic [ADDR_WIDTH-1:0]   dest_r;
    logic [ADDR_WIDTH-1:0]   rem_r;
    logic [NW-1:0]           n_r;
    logic [NW-1:0]           idx_r;
    logic [DATA_WIDTH-1:0]   buf_r [MAX_BURST];
    logic [DATA_WIDTH-1:0]   w_data_r;
    logic                    done_r;
    logic                    error_r;
    logic                    zero_r;
    logic                    ar_valid_r;
    logic                    r_ready_r;
    logic                    aw_valid_r;
    logic                    w_valid_r;
    logic                    w_last_r;
    logic                    b_ready_r;

    logic [ADDR_WIDTH-1:0]   beats_s;
    logic [ADDR_WIDTH-1:0]   step_s;
    logic [ADDR_WIDTH-1:0]   src_nx_s;
    logic [ADDR_WIDTH-1:0]   dest_nx_s;
    logic [ADDR_WIDTH-1:0]   rem_nx_s;
    logic                    idx_last_s;
    logic                    b_err_s;
    logic                    unused_s;

    // Beats in the next burst: limited by what is left, the buffer, and both 4 KB pages.
    function automatic logic [NW-1:0] chunk_f(input logic [ADDR_WIDTH-1:0] s,
                                              input logic [ADDR_WIDTH-1:0] d,
                                              input logic [ADDR_WIDTH-1:0] r);
        logic [ADDR_WIDTH-1:0] n_v;
        logic [ADDR_WIDTH-1:0] sb_v;
        logic [ADDR_WIDTH-1:0] db_v;
        logic [ADDR_WIDTH-1:0] mb_v;
        mb_v = ADDR_WIDTH'(MAX_BURST);
        sb_v = ADDR_WIDTH'((13'h1000 - {1'b0, s[11:0]}) >> SHIFT);
        db_v = ADDR_WIDTH'((13'h1000 - {1'b0, d[11:0]}) >> SHIFT);
        n_v  = r;
        n_v  = (n_v > mb_v) ? mb_v : n_v;
        n_v  = (n_v > sb_v) ? sb_v : n_v;
        n_v  = (n_v > db_v) ? db_v : n_v;
        return n_v[NW-1:0];
    endfunction

    assign beats_s    = length >> SHIFT;
    assign step_s     = ADDR_WIDTH'(n_r) << SHIFT;
    assign src_nx_s   = src_r + step_s;
    assign dest_nx_s  = dest_r + step_s;
    assign rem_nx_s   = rem_r - ADDR_WIDTH'(n_r);
    assign idx_last_s = (idx_r == (n_r - N_ONE));
    assign b_err_s    = error_r | (b_resp != 2'b00);
    assign unused_s   = r_last;

    assign done     = done_r;
    assign error    = error_r;
    assign ar_addr  = src_r;
    assign ar_len   = 8'(n_r - N_ONE);
    assign ar_size  = 3'(SHIFT);
    assign ar_burst = 2'b01;
    assign ar_valid = ar_valid_r;
    assign r_ready  = r_ready_r;
    assign aw_addr  = dest_r;
    assign aw_len   = 8'(n_r - N_ONE);
    assign aw_size  = 3'(SHIFT);
    assign aw_burst = 2'b01;
    assign aw_valid = aw_valid_r;
    assign w_data   = w_data_r;
    assign w_strb   = {BYTES{1'b1}};
    assign w_last   = w_last_r;
    assign w_valid  = w_valid_r;
    assign b_ready  = b_ready_r;

    // Transfer sequencer: one read burst into the buffer, then one write burst out of it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            src_r      <= {ADDR_WIDTH{1'b0}};
            dest_r     <= {ADDR_WIDTH{1'b0}};
            rem_r      <= {ADDR_WIDTH{1'b0}};
            n_r        <= {NW{1'b0}};
            idx_r      <= {NW{1'b0}};
            w_data_r   <= {DATA_WIDTH{1'b0}};
            done_r     <= 1'b1;
            error_r    <= 1'b0;
            zero_r     <= 1'b0;
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            w_last_r   <= 1'b0;
            b_ready_r  <= 1'b0;
            for (int i = 0; i < MAX_BURST; i++) begin
                buf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (zero_r) begin
                        // zero-length request: done drops for exactly one cycle
                        done_r <= 1'b1;
                        zero_r <= 1'b0;
                    end else if (en) begin
                        src_r   <= src_addr;
                        dest_r  <= dest_addr;
                        rem_r   <= beats_s;
                        error_r <= 1'b0;
                        done_r  <= 1'b0;
                        idx_r   <= {NW{1'b0}};
                        if (beats_s == {ADDR_WIDTH{1'b0}}) begin
                            zero_r <= 1'b1;
                        end else begin
                            n_r        <= chunk_f(src_addr, dest_addr, beats_s);
                            ar_valid_r <= 1'b1;
                            state_r    <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (ar_ready) begin
                        ar_valid_r <= 1'b0;
                        r_ready_r  <= 1'b1;
                        idx_r      <= {NW{1'b0}};
                        state_r    <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_valid) begin
                        buf_r[idx_r[IW-1:0]] <= r_data;
                        if (r_resp != 2'b00) begin
                            error_r <= 1'b1;
                        end
                        // beat count, not r_last, closes the burst
                        if (idx_last_s) begin
                            r_ready_r  <= 1'b0;
                            aw_valid_r <= 1'b1;
                            idx_r      <= {NW{1'b0}};
                            state_r    <= ST_WADDR;
                        end else begin
                            idx_r <= idx_r + N_ONE;
                        end
                    end
                end
                ST_WADDR: begin
                    if (aw_ready) begin
                        aw_valid_r <= 1'b0;
                        w_valid_r  <= 1'b1;
                        w_data_r   <= buf_r[0];
                        w_last_r   <= (n_r == N_ONE);
                        state_r    <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_ready) begin
                        if (idx_last_s) begin
                            w_valid_r <= 1'b0;
                            w_last_r  <= 1'b0;
                            b_ready_r <= 1'b1;
                            state_r   <= ST_WRESP;
                        end else begin
                            idx_r    <= idx_r + N_ONE;
                            w_data_r <= buf_r[IW'(idx_r + N_ONE)];
                            w_last_r <= ((idx_r + N_TWO) == n_r);
                        end
                    end
                end
                ST_WRESP: begin
                    if (b_valid) begin
                        b_ready_r <= 1'b0;
                        error_r   <= b_err_s;
                        src_r     <= src_nx_s;
                        dest_r    <= dest_nx_s;
                        rem_r     <= rem_nx_s;
                        if ((rem_nx_s == {ADDR_WIDTH{1'b0}}) || b_err_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            n_r        <= chunk_f(src_nx_s, dest_nx_s, rem_nx_s);
                            ar_valid_r <= 1'b1;
                            state_r    <= ST_RADDR;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_dma_mover.sv
// Bench for nasti_dma_mover: AXI slave with optional stalls, a transfer-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_nasti_dma_mover;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MB = 16;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          areset, en;
    logic [AW-1:0] src_addr, dest_addr, length;
    logic          done, error;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [7:0]    ar_len, aw_len;
    logic [2:0]    ar_size, aw_size;
    logic [1:0]    ar_burst, aw_burst, r_resp, b_resp;
    logic          ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic          aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic [DW-1:0] r_data, w_data;
    logic [DW/8-1:0] w_strb;

    nasti_dma_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .aclk(aclk), .areset(areset), .en(en),
        .src_addr(src_addr), .dest_addr(dest_addr), .length(length),
        .done(done), .error(error),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source memory contents as a pure function of byte address.
    function automatic logic [63:0] mem_f(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0] + 32'h0000_1234};
    endfunction

    // ---------------- AXI slave ----------------
    bit            stall = 1'b0;
    int            inj_beat = -1;
    int            r_cnt = 0;
    logic [63:0]   rq_addr[$];
    int            rq_len[$];
    int            r_idx, b_pend;

    function automatic bit go();
        return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    initial begin
        bit s_rst, s_ar, s_r, s_wl, s_b;
        logic [63:0] s_ara;
        int s_arl;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        r_idx = 0; b_pend = 0;
        forever begin
            @(negedge aclk);
            s_rst = areset;
            s_ar  = ar_valid && ar_ready;
            s_ara = ar_addr;
            s_arl = int'(ar_len);
            s_r   = r_valid && r_ready;
            s_wl  = w_valid && w_ready && w_last;
            s_b   = b_valid && b_ready;
            @(posedge aclk);
            #1;
            if (s_rst) begin
                rq_addr.delete(); rq_len.delete(); r_idx = 0; b_pend = 0;
                ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
                aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
            end else begin
                if (s_ar) begin
                    rq_addr.push_back(s_ara);
                    rq_len.push_back(s_arl);
                end
                if (s_r && rq_addr.size() > 0) begin
                    r_cnt++;
                    r_idx++;
                    if (r_idx > rq_len[0]) begin
                        void'(rq_addr.pop_front());
                        void'(rq_len.pop_front());
                        r_idx = 0;
                    end
                end
                if (s_wl) b_pend++;
                if (s_b) b_pend--;
                ar_ready = go();
                aw_ready = go();
                w_ready  = go();
                if (!r_valid || s_r) begin
                    if (rq_addr.size() > 0 && go()) begin
                        r_valid = 1'b1;
                        r_data  = mem_f(rq_addr[0] + 64'(r_idx) * 64'd8);
                        r_last  = (r_idx == rq_len[0]);
                        r_resp  = (r_cnt == inj_beat) ? 2'b10 : 2'b00;
                    end else begin
                        r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
                    end
                end
                if (!b_valid || s_b) b_valid = (b_pend > 0) && go();
            end
        end
    end

    // ---------------- transfer-level model ----------------
    bit          chk_en = 1'b0, busy_m = 1'b0, exp_done_m = 1'b1, err_m = 1'b0;
    bit          zero_m = 1'b0, ar1_m = 1'b0;
    int          bursts_m = 0, w_allow = 0, w_cnt = 0;
    logic [63:0] ar_exp_a[$], aw_exp_a[$], w_exp_d[$], ar_log_a[$];
    int          ar_exp_l[$], aw_exp_l[$], ar_log_l[$];
    bit          w_exp_l[$];
    bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wl;
    logic [63:0] p_ara, p_awa, p_wd;
    logic [7:0]  p_arl, p_awl;

    task automatic clear_exp();
        ar_exp_a.delete(); ar_exp_l.delete(); aw_exp_a.delete(); aw_exp_l.delete();
        w_exp_d.delete(); w_exp_l.delete();
    endtask

    // Split a request into the bursts and write beats it must produce.
    task automatic plan(input logic [63:0] s_in, input logic [63:0] d_in, input logic [63:0] l);
        logic [63:0] s, d, rem, n, sb, db;
        s = s_in; d = d_in; rem = l >> 3; bursts_m = 0;
        while (rem != 64'd0) begin
            n  = (rem > 64'd16) ? 64'd16 : rem;
            sb = (64'd4096 - (s % 64'd4096)) / 64'd8;
            db = (64'd4096 - (d % 64'd4096)) / 64'd8;
            if (n > sb) n = sb;
            if (n > db) n = db;
            ar_exp_a.push_back(s); ar_exp_l.push_back(int'(n) - 1);
            aw_exp_a.push_back(d); aw_exp_l.push_back(int'(n) - 1);
            for (int i = 0; i < int'(n); i++) begin
                w_exp_d.push_back(mem_f(s + 64'(i) * 64'd8));
                w_exp_l.push_back(i == int'(n) - 1);
            end
            s = s + n * 64'd8; d = d + n * 64'd8; rem = rem - n;
            bursts_m++;
        end
    endtask

    initial begin
        bit idle_now;
        forever begin
            @(negedge aclk);
            if (areset) begin
                chk_en = 1'b1; busy_m = 1'b0; exp_done_m = 1'b1; err_m = 1'b0;
                zero_m = 1'b0; ar1_m = 1'b0; w_allow = 0; clear_exp();
                p_arv = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
                continue;
            end
            if (!chk_en) continue;
            idle_now = !busy_m && !zero_m;
            check("done", 64'(done), 64'(exp_done_m));
            check("error", 64'(error), 64'(err_m));
            if (!busy_m)
                check("idle_outputs", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
            if (ar1_m) begin
                check("ar_valid_after_start", 64'(ar_valid), 64'd1);
                ar1_m = 1'b0;
            end
            if (p_arv && !p_arr) begin
                check("ar_hold_valid", 64'(ar_valid), 64'd1);
                check("ar_hold_addr", ar_addr, p_ara);
                check("ar_hold_len", 64'(ar_len), 64'(p_arl));
            end
            if (p_awv && !p_awr) begin
                check("aw_hold_valid", 64'(aw_valid), 64'd1);
                check("aw_hold_addr", aw_addr, p_awa);
                check("aw_hold_len", 64'(aw_len), 64'(p_awl));
            end
            if (p_wv && !p_wr) begin
                check("w_hold_valid", 64'(w_valid), 64'd1);
                check("w_hold_data", w_data, p_wd);
                check("w_hold_last", 64'(w_last), 64'(p_wl));
            end
            if (ar_valid && ar_ready) begin
                ar_log_a.push_back(ar_addr); ar_log_l.push_back(int'(ar_len));
                check("ar_expected", 64'(ar_exp_a.size() != 0), 64'd1);
                if (ar_exp_a.size() != 0) begin
                    check("ar_addr", ar_addr, ar_exp_a.pop_front());
                    check("ar_len", 64'(ar_len), 64'(ar_exp_l.pop_front()));
                end
                check("ar_size", 64'(ar_size), 64'd3);
                check("ar_burst", 64'(ar_burst), 64'd1);
            end
            if (aw_valid && aw_ready) begin
                check("aw_expected", 64'(aw_exp_a.size() != 0), 64'd1);
                if (aw_exp_a.size() != 0) begin
                    check("aw_addr", aw_addr, aw_exp_a.pop_front());
                    check("aw_len", 64'(aw_len), 64'(aw_exp_l.pop_front()));
                end
                check("aw_size", 64'(aw_size), 64'd3);
                check("aw_burst", 64'(aw_burst), 64'd1);
                w_allow += int'(aw_len) + 1;
            end
            if (w_valid && w_ready) begin
                w_cnt++;
                check("w_after_aw", 64'(w_allow > 0), 64'd1);
                if (w_allow > 0) w_allow--;
                check("w_expected", 64'(w_exp_d.size() != 0), 64'd1);
                if (w_exp_d.size() != 0) begin
                    check("w_data", w_data, w_exp_d.pop_front());
                    check("w_last", 64'(w_last), 64'(w_exp_l.pop_front()));
                end
                check("w_strb", 64'(w_strb), 64'hFF);
            end
            if (r_valid && r_ready && r_resp != 2'b00) err_m = 1'b1;
            if (b_valid && b_ready) begin
                if (b_resp != 2'b00) err_m = 1'b1;
                bursts_m--;
                if (bursts_m == 0 || err_m) begin
                    busy_m = 1'b0; exp_done_m = 1'b1;
                    if (err_m) clear_exp();
                    else check("leftover_w", 64'(w_exp_d.size()), 64'd0);
                end
            end
            if (en && idle_now) begin
                err_m = 1'b0; exp_done_m = 1'b0;
                plan(src_addr, dest_addr, length);
                if (bursts_m == 0) zero_m = 1'b1;
                else begin busy_m = 1'b1; ar1_m = 1'b1; end
            end else if (zero_m) begin
                exp_done_m = 1'b1; zero_m = 1'b0;
            end
            p_arv = ar_valid; p_arr = ar_ready; p_ara = ar_addr; p_arl = ar_len;
            p_awv = aw_valid; p_awr = aw_ready; p_awa = aw_addr; p_awl = aw_len;
            p_wv = w_valid; p_wr = w_ready; p_wd = w_data; p_wl = w_last;
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic start(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
        ar_log_a.delete(); ar_log_l.delete(); w_cnt = 0; r_cnt = 0;
        src_addr = s; dest_addr = d; length = l; en = 1'b1;
        @(posedge aclk); #1;
        en = 1'b0;
    endtask

    task automatic run(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
        int cyc;
        start(s, d, l);
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("xfer_done_in_time", 64'(cyc < 5000), 64'd1);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        int cyc;
        areset = 1'b1; en = 1'b0; src_addr = '0; dest_addr = '0; length = '0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        check("reset_done", 64'(done), 64'd1);
        check("reset_error", 64'(error), 64'd0);
        check("reset_ar_valid", 64'(ar_valid), 64'd0);

        // single 8-beat burst
        run(64'h1000, 64'h2000, 64'd64);
        check("t1_ar_count", 64'(ar_log_a.size()), 64'd1);
        check("t1_ar_addr", ar_log_a[0], 64'h1000);
        check("t1_ar_len", 64'(ar_log_l[0]), 64'd7);
        check("t1_w_beats", 64'(w_cnt), 64'd8);
        check("t1_error", 64'(error), 64'd0);

        // two full bursts
        run(64'h1000, 64'h2000, 64'h100);
        check("t2_ar_count", 64'(ar_log_a.size()), 64'd2);
        check("t2_ar1_addr", ar_log_a[1], 64'h1080);
        check("t2_ar1_len", 64'(ar_log_l[1]), 64'd15);

        // 4 KB split on source
        run(64'h0FF0, 64'h3000, 64'h40);
        check("t3_ar0_len", 64'(ar_log_l[0]), 64'd1);
        check("t3_ar1_addr", ar_log_a[1], 64'h1000);
        check("t3_ar1_len", 64'(ar_log_l[1]), 64'd5);

        // random stalls on every channel
        stall = 1'b1;
        run(64'h4000, 64'h8000, 64'h200);
        stall = 1'b0;
        check("t4_ar_count", 64'(ar_log_a.size()), 64'd4);
        check("t4_w_beats", 64'(w_cnt), 64'd64);

        // SLVERR on beat 3 of an 8-beat first burst aborts the rest
        inj_beat = 2;
        run(64'h0FC0, 64'h5000, 64'h100);
        inj_beat = -1;
        check("t5_error", 64'(error), 64'd1);
        check("t5_ar_count", 64'(ar_log_a.size()), 64'd1);
        check("t5_w_beats", 64'(w_cnt), 64'd8);

        // zero length: one-cycle done pulse, clears error
        run(64'h1000, 64'h2000, 64'd0);
        check("t6_error_cleared", 64'(error), 64'd0);
        check("t6_no_ar", 64'(ar_log_a.size()), 64'd0);

        // reset while reading
        start(64'h6000, 64'h7000, 64'h80);
        cyc = 0;
        while (r_ready !== 1'b1 && cyc < 200) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("t7_reached_rdata", 64'(r_ready), 64'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("t7_done", 64'(done), 64'd1);
        check("t7_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
        repeat (3) @(posedge aclk);
        #1;

        // clean transfer after the reset
        run(64'h9000, 64'hA000, 64'h40);
        check("t8_ar_count", 64'(ar_log_a.size()), 64'd1);
        check("t8_w_beats", 64'(w_cnt), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
